// File: rtl/poly_add_ctrl_if.sv
// Bus bundle for poly_add_ctrl: command handshake, A/B read port, mod_add operands,
// result write port, range-check flag and FSM state for debug.
interface poly_add_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int Q_W    = 23
);
  logic              start_i;
  logic [Q_W-1:0]    q_i;
  logic              busy_o;
  logic              done_o;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [Q_W-1:0]    a_rdata_i;
  logic [Q_W-1:0]    b_rdata_i;
  logic [Q_W:0]      add_a_o;
  logic [Q_W:0]      add_b_o;
  logic [Q_W-1:0]    add_q_o;
  logic [Q_W-1:0]    add_c_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [Q_W-1:0]    wr_data_o;
  logic              err_o;
  logic [1:0]        state_o;

  // Controller side.
  modport master (
    input  start_i, q_i, a_rdata_i, b_rdata_i, add_c_i,
    output busy_o, done_o, rd_en_o, rd_addr_o, add_a_o, add_b_o, add_q_o,
           wr_en_o, wr_addr_o, wr_data_o, err_o, state_o
  );

  // Command FSM, memories and mod_add side.
  modport slave (
    output start_i, q_i, a_rdata_i, b_rdata_i, add_c_i,
    input  busy_o, done_o, rd_en_o, rd_addr_o, add_a_o, add_b_o, add_q_o,
           wr_en_o, wr_addr_o, wr_data_o, err_o, state_o
  );
endinterface

// File: rtl/poly_add_ctrl.sv
// Streams A[k], B[k] through an external mod_add and writes C[k] = A[k]+B[k] mod q.
// Optional range check of operands against q enabled by macro POLY_ADD_RANGE_CHK_EN.
module poly_add_ctrl #(
  parameter int N_COEF = 256,
  parameter int ADDR_W = 8,
  parameter int Q_W    = 23
) (
  input  logic          clk_i,
  input  logic          rst_i,
  poly_add_ctrl_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEF - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_cnt;
  logic [Q_W-1:0]    q_lat;
  logic              start_acc;

  logic              s1_vld;
  logic [ADDR_W-1:0] s1_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [Q_W-1:0]    wr_data;

  // Handshake: start_i is a level request honoured only in IDLE (never queued);
  // done_o is a one-cycle pulse after the final write, busy_o spans first read to last write.
  assign start_acc = (state == S_IDLE) && bus.start_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      rd_cnt <= '0;
      q_lat  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            q_lat  <= bus.q_i;
            rd_cnt <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          // Counter returns to zero instead of walking past the last coefficient.
          if (rd_cnt == LAST_ADDR) begin
            rd_cnt <= '0;
            state  <= S_DRAIN;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (wr_en && (wr_addr == LAST_ADDR)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1 captures the mod_add result; stage 2 presents it to the result RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      s1_vld  <= (state == S_RUN);
      s1_addr <= rd_cnt;
      wr_en   <= s1_vld;
      wr_addr <= s1_addr;
      if (s1_vld) wr_data <= bus.add_c_i;
    end
  end

  assign bus.busy_o    = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done_o    = (state == S_DONE);
  assign bus.rd_en_o   = (state == S_RUN);
  assign bus.rd_addr_o = rd_cnt;
  assign bus.add_a_o   = {1'b0, bus.a_rdata_i};
  assign bus.add_b_o   = {1'b0, bus.b_rdata_i};
  assign bus.add_q_o   = q_lat;
  assign bus.wr_en_o   = wr_en;
  assign bus.wr_addr_o = wr_addr;
  assign bus.wr_data_o = wr_data;
  assign bus.state_o   = state;

`ifdef POLY_ADD_RANGE_CHK_EN
  logic range_bad;
  logic err_q;

  // Flag is visible in the same stage-1 cycle as the offending data, then held.
  assign range_bad = s1_vld && ((bus.a_rdata_i >= q_lat) || (bus.b_rdata_i >= q_lat));

  always_ff @(posedge clk_i) begin
    if (rst_i)          err_q <= 1'b0;
    else if (start_acc) err_q <= 1'b0;
    else if (range_bad) err_q <= 1'b1;
  end

  assign bus.err_o = err_q || range_bad;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign bus.err_o = 1'b0;
`endif

endmodule
